// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: next-PC select encodings, address map defaults
// and the branch offset helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int          IM_DEPTH_DEF = 1024;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  // Word offset of a beq-style branch: sign-extended and scaled to bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, taken branch, j/jal and jr.
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic        valid_d,
  input  npc_sel_e    npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] reg_rs,
  output logic [31:0] npc
);

  logic [31:0] pc_seq;
  logic [31:0] pc_br;

  assign pc_seq = pc_f + 32'd4;
  assign pc_br  = pc_d + 32'd4 + br_offset(imm16);

  // NOTE: npc gets a default first so no path through the case can infer a latch.
  always_comb begin
    npc = pc_seq;
    // A bubble in ID carries no redirect, whatever its control fields say.
    if (valid_d) begin
      case (npc_sel)
        NPC_SEQ: npc = pc_seq;
        NPC_BR:  npc = br_taken ? pc_br : pc_seq;
        NPC_J:   npc = {pc_d[31:28], index26, 2'b00};
        NPC_JR:  npc = reg_rs;
        default: npc = pc_seq;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, IM address, and the IF/ID pipeline register.
// Redirects come from ID and land after the delay slot, which is never flushed.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int          IM_DEPTH = IM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [1:0]  NPCSel,
  input  logic        BrTaken,
  input  logic [15:0] Imm16_D,
  input  logic [25:0] Index26_D,
  input  logic [31:0] RegRs_D,
  output logic [31:0] IM_Addr,
  input  logic [31:0] IM_Instr,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        Valid_D,
  output logic        AddrErr_D
);

  localparam logic [31:0] IM_END = IM_BASE + 32'(4 * IM_DEPTH);

  logic [31:0] pc_f;
  logic [31:0] npc;
  logic [31:0] instr_f;
  logic        err_f;

  assign IM_Addr = pc_f;
  assign err_f   = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f >= IM_END);
  assign instr_f = err_f ? NOP : IM_Instr;

  npc_calc u_npc_calc (
    .pc_f     (pc_f),
    .pc_d     (PC_D),
    .valid_d  (Valid_D),
    .npc_sel  (npc_sel_e'(NPCSel)),
    .br_taken (BrTaken),
    .imm16    (Imm16_D),
    .index26  (Index26_D),
    .reg_rs   (RegRs_D),
    .npc      (npc)
  );

  // NOTE: reset sits in the sensitivity list and is tested first, so it acts at once and overrides Stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f      <= RESET_PC;
      Instr_D   <= NOP;
      PC_D      <= '0;
      PC8_D     <= '0;
      Valid_D   <= 1'b0;
      AddrErr_D <= 1'b0;
    end else if (!Stall) begin
      pc_f      <= npc;
      Instr_D   <= instr_f;
      PC_D      <= pc_f;
      PC8_D     <= pc_f + 32'd8;
      Valid_D   <= 1'b1;
      AddrErr_D <= err_f;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset-during-stall
// sequence, and randomized redirects checked against an architectural PC model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic [1:0]  NPCSel;
  logic        BrTaken;
  logic [15:0] Imm16_D;
  logic [25:0] Index26_D;
  logic [31:0] RegRs_D;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Instr;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        Valid_D;
  logic        AddrErr_D;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the IF stage architecturally holds.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .Stall     (Stall),
    .NPCSel    (NPCSel),
    .BrTaken   (BrTaken),
    .Imm16_D   (Imm16_D),
    .Index26_D (Index26_D),
    .RegRs_D   (RegRs_D),
    .IM_Addr   (IM_Addr),
    .IM_Instr  (IM_Instr),
    .Instr_D   (Instr_D),
    .PC_D      (PC_D),
    .PC8_D     (PC8_D),
    .Valid_D   (Valid_D),
    .AddrErr_D (AddrErr_D)
  );

  // Instruction memory stand-in: a distinct non-zero word per address.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  assign IM_Instr = im_word(IM_Addr);

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h3000 + 4 * 1024);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".IM_Addr"},   IM_Addr,          m_pc);
    check({tag, ".Instr_D"},   Instr_D,          m_instr);
    check({tag, ".PC_D"},      PC_D,             m_pcd);
    check({tag, ".PC8_D"},     PC8_D,            m_pc8);
    check({tag, ".Valid_D"},   32'(Valid_D),     32'(m_valid));
    check({tag, ".AddrErr_D"}, 32'(AddrErr_D),   32'(m_err));
  endtask

  task automatic model_reset();
    m_pc = 32'h3000; m_instr = '0; m_pcd = '0; m_pc8 = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  // Reset asserted mid-cycle, checked before any clock edge, then released.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    reset = 1'b0;
  endtask

  // One rising edge with the currently driven inputs, then model update and compare.
  task automatic tick(input string tag);
    logic [31:0] nxt;
    logic [1:0]  sel;
    sel = m_valid ? NPCSel : 2'b00;
    case (sel)
      2'b01:   nxt = BrTaken ? m_pcd + 4 + 32'(int'($signed(Imm16_D)) * 4) : m_pc + 4;
      2'b10:   nxt = (m_pcd & 32'hF000_0000) | (32'(Index26_D) * 4);
      2'b11:   nxt = RegRs_D;
      default: nxt = m_pc + 4;
    endcase
    @(posedge clk);
    #1;
    if (!Stall) begin
      m_err   = bad_addr(m_pc);
      m_instr = m_err ? 32'h0 : im_word(m_pc);
      m_pcd   = m_pc;
      m_pc8   = m_pc + 8;
      m_valid = 1'b1;
      m_pc    = nxt;
    end
    check_model(tag);
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic        br;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] addr;
    logic [31:0] pcd;
    logic        valid;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic stall, input logic [1:0] sel,
                              input logic br, input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] rs, input logic [31:0] addr,
                              input logic [31:0] pcd, input logic valid, input logic err);
    vec_t v;
    v.rst = rst; v.stall = stall; v.sel = sel; v.br = br; v.imm = imm; v.idx = idx;
    v.rs = rs; v.addr = addr; v.pcd = pcd; v.valid = valid; v.err = err;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    logic [31:0] exp_instr;

    //                rst stall sel   br imm       idx         rs            addr          pcd           v  e
    vecs[0]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'h3000, 1, 0);
    vecs[1]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h3008, 32'h3004, 1, 0);
    vecs[2]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h300C, 32'h3008, 1, 0);
    vecs[3]  = mk(1, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,    0, 0);
    vecs[4]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'h3000, 1, 0);
    vecs[5]  = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h3008, 32'h3004, 1, 0);
    vecs[6]  = mk(0, 0, 2'b01, 1, 16'hFFFE, 26'h0,     32'h0,        32'h3000, 32'h3008, 1, 0);
    vecs[7]  = mk(0, 1, 2'b10, 0, 16'h0000, 26'hC10,   32'h0,        32'h3000, 32'h3008, 1, 0);
    vecs[8]  = mk(0, 1, 2'b10, 0, 16'h0000, 26'hC10,   32'h0,        32'h3000, 32'h3008, 1, 0);
    vecs[9]  = mk(0, 0, 2'b10, 0, 16'h0000, 26'hC10,   32'h0,        32'h3040, 32'h3000, 1, 0);
    vecs[10] = mk(0, 0, 2'b11, 0, 16'h0000, 26'h0,     32'h3002,     32'h3002, 32'h3040, 1, 0);
    vecs[11] = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h3006, 32'h3002, 1, 1);
    vecs[12] = mk(0, 0, 2'b11, 0, 16'h0000, 26'h0,     32'h3FFC,     32'h3FFC, 32'h3006, 1, 1);
    vecs[13] = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h4000, 32'h3FFC, 1, 0);
    vecs[14] = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h4004, 32'h4000, 1, 1);
    vecs[15] = mk(0, 0, 2'b01, 0, 16'h0010, 26'h0,     32'h0,        32'h4008, 32'h4004, 1, 1);
    vecs[16] = mk(1, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,    0, 0);
    vecs[17] = mk(0, 0, 2'b11, 0, 16'h0000, 26'h0,     32'h5000,     32'h3004, 32'h3000, 1, 0);
    vecs[18] = mk(0, 0, 2'b11, 0, 16'h0000, 26'h0,     32'h2FFC,     32'h2FFC, 32'h3004, 1, 0);
    vecs[19] = mk(0, 0, 2'b00, 0, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h2FFC, 1, 1);

    reset = 1'b1; Stall = 1'b0; NPCSel = 2'b00; BrTaken = 1'b0;
    Imm16_D = '0; Index26_D = '0; RegRs_D = '0;
    #12;
    model_reset();
    check_model("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      Stall = vecs[i].stall; NPCSel = vecs[i].sel; BrTaken = vecs[i].br;
      Imm16_D = vecs[i].imm; Index26_D = vecs[i].idx; RegRs_D = vecs[i].rs;
      if (vecs[i].rst) do_reset($sformatf("vec%0d", i));
      else             tick($sformatf("vec%0d", i));
      exp_instr = (vecs[i].err || !vecs[i].valid) ? 32'h0 : im_word(vecs[i].pcd);
      check($sformatf("vec%0d.addr", i),  IM_Addr,        vecs[i].addr);
      check($sformatf("vec%0d.pcd", i),   PC_D,           vecs[i].pcd);
      check($sformatf("vec%0d.pc8", i),   PC8_D,          vecs[i].valid ? vecs[i].pcd + 8 : 32'h0);
      check($sformatf("vec%0d.valid", i), 32'(Valid_D),   32'(vecs[i].valid));
      check($sformatf("vec%0d.err", i),   32'(AddrErr_D), 32'(vecs[i].err));
      check($sformatf("vec%0d.instr", i), Instr_D,        exp_instr);
    end

    // Reset asserted during a stall that follows a taken branch.
    Stall = 1'b0; NPCSel = 2'b00; BrTaken = 1'b0;
    do_reset("s6.pre");
    tick("s6.seq0");
    tick("s6.seq1");
    NPCSel = 2'b01; BrTaken = 1'b1; Imm16_D = 16'h0004;
    tick("s6.br");
    check("s6.target", IM_Addr, 32'h3018);
    Stall = 1'b1; NPCSel = 2'b00; BrTaken = 1'b0;
    tick("s6.stall");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("s6.async_pc", IM_Addr, 32'h3000);
    check("s6.async_valid", 32'(Valid_D), 32'h0);
    @(posedge clk);
    #1;
    check_model("s6.rst_stall_edge");
    @(negedge clk);
    reset = 1'b0;
    tick("s6.stall_after");
    Stall = 1'b0;
    tick("s6.release");
    check("s6.release_pc", IM_Addr, 32'h3004);

    // Randomized redirects, stalls and occasional resets against the model.
    for (int n = 0; n < 400; n++) begin
      Stall     = ($urandom % 5) == 0;
      NPCSel    = 2'($urandom);
      BrTaken   = 1'($urandom);
      Imm16_D   = 16'($urandom_range(0, 64)) - 16'd32;
      Index26_D = 26'($urandom_range(32'h0BF0, 32'h1010));
      RegRs_D   = 32'($urandom_range(32'h2FF0, 32'h4010));
      if (($urandom % 4) != 0) RegRs_D[1:0] = 2'b00;
      if (($urandom % 97) == 0) do_reset($sformatf("rnd%0d.rst", n));
      else                      tick($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
